// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: IDLE/RUN/DONE FSM with stall support.
// Optional signed-overflow output oOVF enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic iCLK,
   input  logic iRST_N,
   input  logic iSTART,
   input  logic iVALID,
   input  logic iA,
   input  logic iB,
   output logic oREADY,
   output logic oDIFF,
   output logic oDIFF_VALID,
   output logic oBORROW,
`ifdef SERIAL_SUB_OVF_EN
   output logic oOVF,
`endif
   output logic oDONE,
   output logic oBUSY
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_borrow;
   logic          w_borrow_nxt;
   logic          r_diff;
   logic          r_diff_valid;
   logic          r_borrow_out;
   logic          w_accept;
   logic          w_last;
   logic          w_diff;
   logic          w_bnext;

   assign w_accept = (r_state == S_RUN) && iVALID;
   assign w_last   = (r_cnt == LAST);
   assign w_diff   = iA ^ iB ^ r_borrow;
   assign w_bnext  = (~iA & iB) | (~(iA ^ iB) & r_borrow);

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_borrow_nxt = r_borrow;
      unique case (r_state)
         S_IDLE: begin
            if (iSTART) begin
               w_state_nxt  = S_RUN;
               w_cnt_nxt    = '0;
               w_borrow_nxt = 1'b0;
            end
         end
         S_RUN: begin
            if (w_accept) begin
               w_borrow_nxt = w_bnext;
               // counter parks on the last index instead of wrapping
               if (w_last) w_state_nxt = S_DONE;
               else        w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_borrow <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_borrow <= w_borrow_nxt;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_diff       <= 1'b0;
         r_diff_valid <= 1'b0;
         r_borrow_out <= 1'b0;
      end else begin
         r_diff_valid <= w_accept;
         if (w_accept) r_diff <= w_diff;
         if (w_accept && w_last) r_borrow_out <= w_bnext;
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   logic r_ovf;

   // borrow into the MSB is the running borrow when the MSB is accepted
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_ovf <= 1'b0;
      end else if (w_accept && w_last) begin
         r_ovf <= r_borrow ^ w_bnext;
      end
   end

   assign oOVF = r_ovf;
`endif

   assign oREADY      = (r_state == S_RUN);
   assign oBUSY       = (r_state == S_RUN) || (r_state == S_DONE);
   assign oDONE       = (r_state == S_DONE);
   assign oDIFF       = r_diff;
   assign oDIFF_VALID = r_diff_valid;
   assign oBORROW     = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8), directed vectors.
// Driver pushes expected bits/words; negedge monitor pops and compares.
module tb_serial_subtractor;

   logic iCLK = 1'b0;
   logic iRST_N = 1'b0;
   logic iSTART = 1'b0;
   logic iVALID = 1'b0;
   logic iA = 1'b0;
   logic iB = 1'b0;
   logic oREADY;
   logic oDIFF;
   logic oDIFF_VALID;
   logic oBORROW;
   logic oDONE;
   logic oBUSY;
`ifdef SERIAL_SUB_OVF_EN
   logic oOVF;
`endif

   serial_subtractor #(.WIDTH(8)) dut (
      .iCLK(iCLK),
      .iRST_N(iRST_N),
      .iSTART(iSTART),
      .iVALID(iVALID),
      .iA(iA),
      .iB(iB),
      .oREADY(oREADY),
      .oDIFF(oDIFF),
      .oDIFF_VALID(oDIFF_VALID),
      .oBORROW(oBORROW),
`ifdef SERIAL_SUB_OVF_EN
      .oOVF(oOVF),
`endif
      .oDONE(oDONE),
      .oBUSY(oBUSY)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      logic [7:0] diff;
      logic       bor;
      logic       ovf;
      int         cyc;
   } word_t;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic       bq[$];
   word_t      wq[$];
   logic [7:0] acc = '0;
   int         bitpos = 0;
   logic       prev_bor = 1'b0;

   always @(posedge iCLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_ready"}, 32'(oREADY), 0);
      chk({nm, "_diff"}, 32'(oDIFF), 0);
      chk({nm, "_dvalid"}, 32'(oDIFF_VALID), 0);
      chk({nm, "_borrow"}, 32'(oBORROW), 0);
      chk({nm, "_done"}, 32'(oDONE), 0);
      chk({nm, "_busy"}, 32'(oBUSY), 0);
`ifdef SERIAL_SUB_OVF_EN
      chk({nm, "_ovf"}, 32'(oOVF), 0);
`endif
   endtask

   // monitor
   always @(negedge iCLK) begin
      word_t w;
      logic  eb;
      if (!iRST_N) begin
         bitpos = 0;
         acc    = '0;
      end else begin
         if (oDIFF_VALID) begin
            if (bq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_bit actual=%0b required=none", oDIFF);
            end else begin
               eb = bq.pop_front();
               chk("diff_bit", 32'(oDIFF), 32'(eb));
            end
            if (bitpos < 8) acc[bitpos] = oDIFF;
            bitpos++;
         end
         if (oDONE) begin
            if (wq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               w = wq.pop_front();
               chk("word", 32'(acc), 32'(w.diff));
               chk("borrow", 32'(oBORROW), 32'(w.bor));
`ifdef SERIAL_SUB_OVF_EN
               chk("ovf", 32'(oOVF), 32'(w.ovf));
`endif
               chk("done_cycle", 32'(cyc), 32'(w.cyc));
               chk("done_dvalid", 32'(oDIFF_VALID), 1);
               chk("done_busy_ready", {oBUSY, oREADY}, 32'b10);
            end
            bitpos = 0;
            acc    = '0;
         end
      end
   end

   task automatic run_word(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] d, input logic bo,
                           input logic ov, input int stall,
                           input int glitch_at, input int abort_after);
      int s;
      int n;
      word_t w;
      @(negedge iCLK);
      // junk valid bit alongside start must be ignored
      iSTART = 1'b1;
      iVALID = 1'b1;
      iA     = 1'b1;
      iB     = 1'b0;
      s      = cyc;
      if (abort_after < 0) begin
         w.diff = d;
         w.bor  = bo;
         w.ovf  = ov;
         w.cyc  = s + 9 + stall;
         wq.push_back(w);
      end
      @(negedge iCLK);
      chk("ready_in_run", 32'(oREADY), 1);
      chk("borrow_hold_at_start", 32'(oBORROW), 32'(prev_bor));
      iSTART = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 4 && stall > 0) begin
            iVALID = 1'b0;
            repeat (stall) @(negedge iCLK);
         end
         iVALID = 1'b1;
         iA     = a[i];
         iB     = b[i];
         iSTART = (i == glitch_at);
         bq.push_back(d[i]);
         @(negedge iCLK);
         if (i == abort_after) begin
            iVALID = 1'b0;
            iSTART = 1'b0;
            #1 iRST_N = 1'b0;
            #1 chk_zero("abort");
            @(negedge iCLK);
            @(negedge iCLK);
            iRST_N = 1'b1;
            prev_bor = 1'b0;
            return;
         end
      end
      iVALID = 1'b0;
      iSTART = 1'b0;
      n = 0;
      while (wq.size() != 0 && n < 20) begin
         @(negedge iCLK);
         n++;
      end
      if (wq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=none required=oDONE");
         wq.delete();
      end
      prev_bor = bo;
   endtask

   initial begin
      #1 chk_zero("reset");
      repeat (3) @(negedge iCLK);
      chk_zero("reset_hold");
      iRST_N = 1'b1;
      @(negedge iCLK);
      chk_zero("idle");
      // iVALID in IDLE must not produce output
      iVALID = 1'b1;
      @(negedge iCLK);
      chk("idle_valid_ignored", {oDIFF_VALID, oBUSY}, 0);
      iVALID = 1'b0;

      run_word(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0, -1, -1);
      run_word(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0, -1, -1);
      run_word(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, -1, -1);
      run_word(8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0, 0, -1, -1);
      run_word(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 3, -1, -1);
      run_word(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 0, -1, -1);
      run_word(8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1, 0, -1, -1);
      run_word(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0, -1, 4);
      @(negedge iCLK);
      chk_zero("post_abort");
      run_word(8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 0, -1, -1);
      run_word(8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1, 0, 3, -1);
      run_word(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0, 0, -1);

      repeat (5) @(negedge iCLK);
      chk("bits_left", 32'(bq.size()), 0);
      chk("words_left", 32'(wq.size()), 0);
      chk("final_idle", {oBUSY, oREADY, oDONE}, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, the word length in bits (legal range 2..32).
REQ-002 iCLK  input  1  The module SHALL have a single clock; all state updates on its rising edge.
REQ-003 iRST_N  input  1  The module SHALL have an asynchronous, active-low reset.
REQ-004 iSTART  input  1  The module SHALL accept a start-of-word pulse, sampled only in IDLE.
REQ-005 iVALID  input  1  The module SHALL treat iA/iB as a valid operand bit pair when iVALID=1.
REQ-006 iA  input  1  The module SHALL take minuend bits serially, LSB first.
REQ-007 iB  input  1  The module SHALL take subtrahend bits serially, LSB first.
REQ-008 oREADY  output  1  The module SHALL assert oREADY exactly while in RUN.
REQ-009 oDIFF  output  1  The module SHALL output registered difference bits, LSB first.
REQ-010 oDIFF_VALID  output  1  The module SHALL pulse oDIFF_VALID with each valid oDIFF bit.
REQ-011 oBORROW  output  1  The module SHALL output the final borrow-out of the last completed word.
REQ-012 oDONE  output  1  The module SHALL pulse oDONE for one cycle at word completion.
REQ-013 oBUSY  output  1  The module SHALL assert oBUSY while in RUN or DONE.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 In IDLE, iSTART=1 SHALL move the FSM to RUN next cycle, clearing the running borrow and the bit counter to 0.
REQ-016 In IDLE, iVALID SHALL be ignored, including when it is coincident with iSTART.
REQ-017 In RUN/DONE, iSTART SHALL be ignored.
REQ-018 A bit SHALL be accepted on each RUN cycle with iVALID=1: diff = iA^iB^b; b_next = (~iA&iB) | (~(iA^iB)&b).
REQ-019 oDIFF/oDIFF_VALID SHALL appear one cycle after acceptance; oDIFF_VALID SHALL be 0 in all other cycles; oDIFF SHALL hold its last value when not valid.
REQ-020 A RUN cycle with iVALID=0 SHALL be a stall: no acceptance, no counter or borrow change, unbounded length.
REQ-021 Acceptance of bit WIDTH-1 SHALL move the FSM to DONE and latch b_next into oBORROW in the same edge.
REQ-022 DONE SHALL last exactly one cycle with oDONE=1, then return to IDLE.
REQ-023 The last oDIFF_VALID pulse and oDONE SHALL coincide.
REQ-024 oBORROW SHALL hold its value until the next word completes; it SHALL NOT change at iSTART.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH)) bits and SHALL NOT wrap within a word.

Reset
REQ-026 iRST_N=0 SHALL immediately force IDLE and clear the counter, running borrow, oREADY, oDIFF, oDIFF_VALID, oBORROW, oDONE, oBUSY and oOVF to 0, including mid-word.
REQ-027 After reset release, the first word SHALL require a fresh iSTART; partial words SHALL NOT resume.

Configuration
REQ-028 When SERIAL_SUB_OVF_EN is defined, output oOVF (1 bit) SHALL exist; it SHALL be the signed overflow (borrow into MSB XOR borrow out of MSB), latched and held exactly like oBORROW.
REQ-029 When SERIAL_SUB_OVF_EN is undefined, port oOVF and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-030 WIDTH=8, A=0x05, B=0x03, iVALID held 1 -> oDIFF bits 0,1,0,0,0,0,0,0 (0x02); oBORROW=0; oDONE 9 cycles after iSTART.
REQ-031 A=0x03, B=0x05 -> result 0xFE, oBORROW=1.
REQ-032 With SERIAL_SUB_OVF_EN: A=0x80, B=0x01 -> result 0x7F, oBORROW=0, oOVF=1; then A=0x7F, B=0x01 -> 0x7E, oOVF=0.
REQ-033 A=0x05, B=0x03 with iVALID=0 for 3 cycles after bit 3 -> no oDIFF_VALID during the stall; result 0x02; oDONE 3 cycles later than REQ-030.
REQ-034 iRST_N=0 after bit 4 of a word -> all outputs 0 and IDLE immediately; then iSTART, A=0xFF, B=0x0F -> 0xF0, oBORROW=0.
REQ-035 iSTART pulsed during RUN -> ignored, with word result and oDONE timing identical to the undisturbed case.
